// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Single-clock show-ahead FIFO: simple-dual-port RAM with 1-cycle read latency
// feeding a small register prefetch buffer whose head drives rd_data.
module ipml_sync_prefetch_fifo_v2_0 #(
   parameter int c_DATA_WIDTH  = 32,
   parameter int c_DEPTH_WIDTH = 4,
   parameter int c_PF_DEPTH    = 2,
   parameter int c_AF_LEVEL    = 14,
   parameter int c_AE_LEVEL    = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [c_DATA_WIDTH-1:0]    wr_data,
   input  logic                       wr_en,
   output logic                       wr_vld,
   output logic [c_DATA_WIDTH-1:0]    rd_data,
   input  logic                       rd_en,
   output logic                       rd_vld,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [c_DEPTH_WIDTH:0]     wr_water_level,
   output logic [c_DEPTH_WIDTH+1:0]   rd_water_level,
   output logic                       overflow
);

   localparam int DEPTH = 1 << c_DEPTH_WIDTH;
   localparam logic [c_DEPTH_WIDTH:0]   FULL_L = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
   localparam logic [c_DEPTH_WIDTH:0]   AF_L   = c_AF_LEVEL[c_DEPTH_WIDTH:0];
   localparam logic [c_DEPTH_WIDTH+1:0] AE_L   = c_AE_LEVEL[c_DEPTH_WIDTH+1:0];
   localparam logic [2:0]               PF_L   = c_PF_DEPTH[2:0];

   logic [c_DEPTH_WIDTH-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [c_DEPTH_WIDTH:0]     mem_cnt_q, mem_cnt_d;
   logic [c_DEPTH_WIDTH+1:0]   rd_lvl_q, rd_lvl_d;
   logic [2:0]                 pf_cnt_q, pf_cnt_d;
   logic [2:0]                 occ_s, wr_idx_s;
   logic                       inflight_q, inflight_d;
   logic                       ovf_q, ovf_d;
   logic                       full_s, wr_acc_s, pop_s, push_s, rd_issue_s;

   logic [c_DATA_WIDTH-1:0]    mem_q [DEPTH];
   logic [c_DATA_WIDTH-1:0]    ram_q;
   logic [c_DATA_WIDTH-1:0]    pf_q [c_PF_DEPTH];
   logic [c_DATA_WIDTH-1:0]    pf_d [c_PF_DEPTH];

   // Event decode; flush masks every same-cycle write, read issue and pop.
   always_comb begin
      full_s     = (mem_cnt_q == FULL_L);
      wr_acc_s   = wr_en & ~full_s & ~flush;
      pop_s      = (pf_cnt_q != 3'd0) & rd_en & ~flush;
      push_s     = inflight_q & ~flush;
      occ_s      = pf_cnt_q + {2'b00, inflight_q};
      // Reissue on a pop when the buffer plus in-flight word exactly fill it.
      rd_issue_s = ~flush & (mem_cnt_q != {(c_DEPTH_WIDTH+1){1'b0}})
                   & ((occ_s < PF_L) | (pop_s & (occ_s == PF_L)));
      wr_idx_s   = pf_cnt_q - {2'b00, pop_s};
   end

   // Next-state for pointers, counters and sticky overflow.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      mem_cnt_d  = mem_cnt_q;
      rd_lvl_d   = rd_lvl_q;
      pf_cnt_d   = pf_cnt_q;
      inflight_d = inflight_q;
      ovf_d      = ovf_q;
      if (flush) begin
         wr_ptr_d   = {c_DEPTH_WIDTH{1'b0}};
         rd_ptr_d   = {c_DEPTH_WIDTH{1'b0}};
         mem_cnt_d  = {(c_DEPTH_WIDTH+1){1'b0}};
         rd_lvl_d   = {(c_DEPTH_WIDTH+2){1'b0}};
         pf_cnt_d   = 3'd0;
         inflight_d = 1'b0;
         ovf_d      = 1'b0;
      end else begin
         wr_ptr_d   = wr_ptr_q + {{(c_DEPTH_WIDTH-1){1'b0}}, wr_acc_s};
         rd_ptr_d   = rd_ptr_q + {{(c_DEPTH_WIDTH-1){1'b0}}, rd_issue_s};
         mem_cnt_d  = mem_cnt_q + {{c_DEPTH_WIDTH{1'b0}}, wr_acc_s}
                                - {{c_DEPTH_WIDTH{1'b0}}, rd_issue_s};
         rd_lvl_d   = rd_lvl_q + {{(c_DEPTH_WIDTH+1){1'b0}}, wr_acc_s}
                               - {{(c_DEPTH_WIDTH+1){1'b0}}, pop_s};
         pf_cnt_d   = pf_cnt_q + {2'b00, push_s} - {2'b00, pop_s};
         inflight_d = rd_issue_s;
         if (wr_en & full_s) begin
            ovf_d = 1'b1;
         end else begin
            ovf_d = ovf_q;
         end
      end
   end

   // Prefetch shift: entries move toward the head on pop, RAM data lands at the tail.
   always_comb begin
      pf_d = pf_q;
      for (int i = 0; i < c_PF_DEPTH; i++) begin
         if (pop_s && ((i + 1) < int'(pf_cnt_q))) begin
            pf_d[i] = pf_q[(i + 1) % c_PF_DEPTH];
         end else begin
            pf_d[i] = pf_q[i];
         end
         if (push_s && (i == int'(wr_idx_s))) begin
            pf_d[i] = ram_q;
         end else begin
            pf_d[i] = pf_d[i];
         end
      end
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= {c_DEPTH_WIDTH{1'b0}};
         rd_ptr_q   <= {c_DEPTH_WIDTH{1'b0}};
         mem_cnt_q  <= {(c_DEPTH_WIDTH+1){1'b0}};
         rd_lvl_q   <= {(c_DEPTH_WIDTH+2){1'b0}};
         pf_cnt_q   <= 3'd0;
         inflight_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         mem_cnt_q  <= mem_cnt_d;
         rd_lvl_q   <= rd_lvl_d;
         pf_cnt_q   <= pf_cnt_d;
         inflight_q <= inflight_d;
         ovf_q      <= ovf_d;
      end
   end

   // Prefetch data registers; reset forces rd_data to zero, flush leaves data alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < c_PF_DEPTH; i++) begin
            pf_q[i] <= {c_DATA_WIDTH{1'b0}};
         end
      end else begin
         pf_q <= pf_d;
      end
   end

   // Inferred simple-dual-port RAM with registered read port.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
      if (rd_issue_s) begin
         ram_q <= mem_q[rd_ptr_q];
      end
   end

   assign rd_data        = pf_q[0];
   assign rd_vld         = (pf_cnt_q != 3'd0);
   assign wr_vld         = ~full_s;
   assign almost_full    = (mem_cnt_q >= AF_L);
   assign almost_empty   = (rd_lvl_q <= AE_L);
   assign wr_water_level = mem_cnt_q;
   assign rd_water_level = rd_lvl_q;
   assign overflow       = ovf_q;

endmodule

// File: doc/ipml_sync_prefetch_fifo_v2_0.md
Name: ipml_sync_prefetch_fifo_v2_0

Overview:
- Single-clock FIFO: inferred simple-dual-port RAM (1-cycle read latency) plus a parametrised register prefetch buffer.
- Output is show-ahead: rd_data is valid whenever rd_vld=1; a word pops on rd_vld & rd_en.
- Adds to the earlier prefetch FIFO:
  - configurable prefetch depth
  - synchronous flush
  - almost-full / almost-empty thresholds
  - water levels
  - sticky overflow flag
- Used between DDR3 read/write paths and video pipelines that run in one clock domain.

Parameters:
- c_DATA_WIDTH, 32, data width, 1..1152.
- c_DEPTH_WIDTH, 4, RAM address width; RAM capacity = 2^c_DEPTH_WIDTH entries, legal 2..20.
- c_PF_DEPTH, 2, prefetch register entries, legal 2..4 (2 is the minimum for 1 word/cycle).
- c_AF_LEVEL, 14, almost_full asserts when RAM occupancy >= this value.
- c_AE_LEVEL, 2, almost_empty asserts when read-side occupancy <= this value.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of all contents.
- wr_data  in  c_DATA_WIDTH  write data.
- wr_en  in  1  write request.
- wr_vld  out  1  space available (~full); a write is accepted when wr_en & wr_vld.
- rd_data  out  c_DATA_WIDTH  head-of-FIFO data.
- rd_en  in  1  read acknowledge.
- rd_vld  out  1  rd_data valid.
- almost_full  out  1  RAM occupancy >= c_AF_LEVEL.
- almost_empty  out  1  read-side occupancy <= c_AE_LEVEL.
- wr_water_level  out  c_DEPTH_WIDTH+1  RAM occupancy, 0..2^c_DEPTH_WIDTH.
- rd_water_level  out  c_DEPTH_WIDTH+2  RAM occupancy + in-flight reads + prefetch count.
- overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (async assert, release on clk): pointers and counters 0, prefetch empty, no read in flight.
  - Output values at reset: wr_vld=1, rd_vld=0, rd_data=0, almost_full=0, almost_empty=1, both levels 0, overflow=0.
- Write: accepted when wr_en & ~full, full = (mem_cnt == 2^c_DEPTH_WIDTH).
  - Accepted write stores at wr_ptr; wr_ptr wraps modulo 2^c_DEPTH_WIDTH.
  - wr_en while full: data dropped, pointers unchanged, overflow set on that edge.
- RAM read issue (combinational), rd_issue = (mem_cnt != 0) & ((pf_cnt + inflight < c_PF_DEPTH) | (pop & pf_cnt + inflight == c_PF_DEPTH)).
  - rd_issue advances rd_ptr (with wrap) and sets inflight for one cycle.
  - Returned data enters the prefetch tail on the next edge.
- Prefetch buffer: register FIFO of c_PF_DEPTH entries. Head drives rd_data; rd_vld = (pf_cnt != 0).
  - Pop on rd_vld & rd_en. rd_en while rd_vld=0 is ignored.
  - Simultaneous pop and push: pf_cnt unchanged; the next entry moves to the head.
  - rd_data holds its last value when rd_vld=0.
- Latency: write accepted on edge E0 into an empty FIFO -> rd_issue during E0..E1 -> rd_vld=1 after E2.
  - rd_data equals the written word after E2.
- Throughput: with c_PF_DEPTH >= 2, steady rd_en=1 and wr_en=1 sustain 1 word/cycle in both directions.
- Counter updates, all registered, reflect the edge's events:
  - mem_cnt changes by +write -rd_issue.
  - rd_water_level changes by +write -pop.
  - Simultaneous write and read on the same edge are legal; they never touch the same address, since rd_issue requires mem_cnt != 0 before the edge.
- almost_full / almost_empty: combinational compares on the registered counts, glitch-free relative to clk.
- Flush (synchronous, highest priority):
  - On an edge with flush=1, the same-cycle write, rd_issue and pop are all ignored.
  - Pointers, counts and prefetch are cleared; any in-flight RAM data is discarded; overflow is cleared.
  - rd_vld=0 after that edge; rd_data keeps its last value.
- Reset mid-operation: same effect as flush, asynchronous, and rd_data is forced to 0.
- Capacity: 2^c_DEPTH_WIDTH RAM entries + c_PF_DEPTH prefetch entries.
  - wr_vld depends only on RAM fullness, so up to 2^c_DEPTH_WIDTH + c_PF_DEPTH words can be held.

Test Plan (defaults: c_DATA_WIDTH=32, c_DEPTH_WIDTH=4, c_PF_DEPTH=2, c_AF_LEVEL=14, c_AE_LEVEL=2):
- Single write 0xA5A5_0001 at E0, rd_en=0 -> rd_vld=1 and rd_data=0xA5A5_0001 after E2; wr_water_level=0 and rd_water_level=1 after E1.
- 18 writes (0..17) with rd_en=0 -> wr_vld=0 after the 18th accepted write; wr_water_level=16, rd_water_level=18; almost_full=1 from wr_water_level=14; a 19th write sets overflow=1 with level unchanged.
- From the full state, rd_en=1 for 18 cycles -> data 0..17 in order, one word per cycle with no rd_vld gap; then rd_vld=0, almost_empty=1, levels 0.
- Continuous wr_en=1 and rd_en=1 for 100 cycles with an incrementing pattern -> 100 words out in order; wr_vld stays 1; rd_water_level settles at a constant value after startup.
- 10 words loaded, flush pulsed in the same cycle as wr_en and rd_en -> after the edge rd_vld=0, levels 0, overflow=0; the next write is read back 3 edges later.
- rst asserted asynchronously mid-stream (between edges) -> rd_vld=0, rd_data=0, wr_vld=1 immediately; after release, a write/read cycle behaves as in scenario 1.
